// File: rtl/pipe_stage_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pipe_stage_buf                                             |
// | Description : Valid/ready pipeline stage buffer. Define PIPE_SKID_EN for |
// |               a 2-entry skid buffer with registered in_ready; otherwise  |
// |               a single entry with combinational in_ready.                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pipe_stage_buf #(
    parameter int                   PAYLOAD_W     = 32,
    parameter logic [PAYLOAD_W-1:0] RESET_PAYLOAD = '0
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [1:0]           occupancy
);

    logic w_accept;
    logic w_pop;

    assign w_accept = in_valid & in_ready;
    assign w_pop    = out_valid & out_ready;

`ifdef PIPE_SKID_EN

    // State encoding doubles as the entry count driven on occupancy.
    localparam logic [1:0] c_EMPTY = 2'd0;
    localparam logic [1:0] c_ONE   = 2'd1;
    localparam logic [1:0] c_FULL  = 2'd2;

    logic [1:0]           state_q, state_d;
    logic                 in_ready_q, in_ready_d;
    logic [PAYLOAD_W-1:0] main_q, main_d;
    logic [PAYLOAD_W-1:0] skid_q, skid_d;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = c_EMPTY;
        end else begin
            case (state_q)
                c_EMPTY: begin
                    if (w_accept) begin
                        state_d = c_ONE;
                        main_d  = in_payload;
                    end
                end
                c_ONE: begin
                    if (w_accept && w_pop) begin
                        main_d = in_payload;
                    end else if (w_accept) begin
                        state_d = c_FULL;
                        skid_d  = in_payload;
                    end else if (w_pop) begin
                        state_d = c_EMPTY;
                    end
                end
                c_FULL: begin
                    if (w_pop) begin
                        state_d = c_ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = c_EMPTY;
            endcase
        end
        in_ready_d = (state_d != c_FULL);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= c_EMPTY;
            in_ready_q <= 1'b1;
            main_q     <= RESET_PAYLOAD;
            skid_q     <= RESET_PAYLOAD;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (state_q != c_EMPTY);
    assign out_payload = main_q;
    assign occupancy   = state_q;

`else

    logic                 valid_q, valid_d;
    logic [PAYLOAD_W-1:0] main_q, main_d;

    always_comb begin
        valid_d = valid_q;
        main_d  = main_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (w_accept) begin
            valid_d = 1'b1;
            main_d  = in_payload;
        end else if (w_pop) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            main_q  <= RESET_PAYLOAD;
        end else begin
            valid_q <= valid_d;
            main_q  <= main_d;
        end
    end

    assign in_ready    = !valid_q || out_ready;
    assign out_valid   = valid_q;
    assign out_payload = main_q;
    assign occupancy   = {1'b0, valid_q};

`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// Self-checking bench for pipe_stage_buf: directed scenarios plus random traffic
// compared against a queue-based model of the buffer.
module tb_pipe_stage_buf;

    localparam logic [31:0] c_RST_PL = 32'hC0DE_0000;
`ifdef PIPE_SKID_EN
    localparam int c_CAP = 2;
`else
    localparam int c_CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_payload = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_payload;
    logic [1:0]  occupancy;

    int errors = 0;
    int checks = 0;
    logic [31:0] model_q[$];

    always #5 clk = ~clk;

    pipe_stage_buf #(.PAYLOAD_W(32), .RESET_PAYLOAD(c_RST_PL)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_payload(in_payload), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_payload(out_payload), .occupancy(occupancy)
    );

    function automatic bit model_in_ready(input bit ordy);
`ifdef PIPE_SKID_EN
        return model_q.size() < c_CAP;
`else
        return (model_q.size() == 0) || ordy;
`endif
    endfunction

    task automatic check_outputs(input string tag);
        logic       exp_v;
        logic [1:0] exp_occ;
        logic       exp_rdy;
        exp_v   = (model_q.size() != 0);
        exp_occ = 2'(model_q.size());
        exp_rdy = model_in_ready(out_ready);
        checks++;
        assert (out_valid === exp_v) else begin
            errors++; $error("FAIL %s out_valid got=%b exp=%b", tag, out_valid, exp_v);
        end
        checks++;
        assert (occupancy === exp_occ) else begin
            errors++; $error("FAIL %s occupancy got=%0d exp=%0d", tag, occupancy, exp_occ);
        end
        checks++;
        assert (in_ready === exp_rdy) else begin
            errors++; $error("FAIL %s in_ready got=%b exp=%b", tag, in_ready, exp_rdy);
        end
        if (exp_v) begin
            checks++;
            assert (out_payload === model_q[0]) else begin
                errors++; $error("FAIL %s out_payload got=%h exp=%h", tag, out_payload, model_q[0]);
            end
        end
        checks++;
        assert (!(out_valid === 1'b1 && out_payload === 32'hDEAD)) else begin
            errors++; $error("FAIL %s flushed payload got=%h exp=not 0000dead", tag, out_payload);
        end
    endtask

    // One clock: drive inputs at the falling edge, check, advance model at the rising edge.
    task automatic step(input bit iv, input logic [31:0] ip, input bit ordy, input bit fl,
                        input string tag, output bit accepted);
        bit pop;
        in_valid = iv; in_payload = ip; out_ready = ordy; flush = fl;
        #1;
        check_outputs(tag);
        accepted = iv && model_in_ready(ordy);
        pop      = (model_q.size() != 0) && ordy;
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            if (pop) void'(model_q.pop_front());
            if (accepted) model_q.push_back(ip);
        end
        @(negedge clk);
        accepted = accepted && !fl;
    endtask

    task automatic check_reset(input string tag);
        checks++;
        assert (out_valid === 1'b0) else begin
            errors++; $error("FAIL %s out_valid got=%b exp=0", tag, out_valid);
        end
        checks++;
        assert (occupancy === 2'd0) else begin
            errors++; $error("FAIL %s occupancy got=%0d exp=0", tag, occupancy);
        end
        checks++;
        assert (out_payload === c_RST_PL) else begin
            errors++; $error("FAIL %s out_payload got=%h exp=%h", tag, out_payload, c_RST_PL);
        end
        checks++;
        assert (in_ready === 1'b1) else begin
            errors++; $error("FAIL %s in_ready got=%b exp=1", tag, in_ready);
        end
    endtask

    // Offer one payload until accepted, with a bounded number of attempts.
    task automatic offer(input logic [31:0] ip, input bit ordy, input string tag);
        bit acc;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) step(1'b1, ip, ordy, 1'b0, tag, acc);
        checks++;
        assert (acc) else begin
            errors++; $error("FAIL %s accept got=0 exp=1 payload=%h", tag, ip);
        end
    endtask

    initial begin
        bit acc;
        bit ordy;

        repeat (2) @(negedge clk);
        check_reset("reset");
        rstn = 1'b1;
        @(negedge clk);

        // Streaming 0x1..0x8 with a free-flowing downstream.
        for (int i = 1; i <= 8; i++) step(1'b1, 32'(i), 1'b1, 1'b0, "stream", acc);
        for (int i = 0; i < 2; i++) step(1'b0, 32'h0, 1'b1, 1'b0, "stream_drain", acc);

        // Backpressure: A and B fill the buffer, C waits upstream.
        step(1'b1, 32'hA, 1'b0, 1'b0, "bp_a", acc);
        step(1'b1, 32'hB, 1'b0, 1'b0, "bp_b", acc);
        step(1'b1, 32'hC, 1'b0, 1'b0, "bp_c_held", acc);
        offer(32'hC, 1'b1, "bp_c");
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0, "bp_drain", acc);

        // Flush with a full buffer and a simultaneous offer of 0xDEAD.
        step(1'b1, 32'h21, 1'b0, 1'b0, "fl_fill", acc);
        step(1'b1, 32'h22, 1'b0, 1'b0, "fl_fill", acc);
        step(1'b1, 32'hDEAD, 1'b1, 1'b1, "flush", acc);
        for (int i = 0; i < 3; i++) step(1'b0, 32'hDEAD, 1'b1, 1'b0, "post_flush", acc);

        // Reset while holding 0x55.
        step(1'b1, 32'h55, 1'b0, 1'b0, "rst_fill", acc);
        step(1'b0, 32'h0, 1'b0, 1'b0, "rst_hold", acc);
        #2 rstn = 1'b0;
        #1 check_reset("rst_async");
        model_q.delete();
        @(posedge clk);
        @(negedge clk);
        check_reset("rst_held");
        rstn = 1'b1;
        step(1'b1, 32'h66, 1'b1, 1'b0, "rst_first", acc);
        step(1'b0, 32'h0, 1'b1, 1'b0, "rst_first_out", acc);
        step(1'b0, 32'h0, 1'b1, 1'b0, "rst_drain", acc);

        // Toggled out_ready under continuous input 0x10 upward.
        begin
            logic [31:0] nxt;
            nxt = 32'h10;
            for (int i = 0; i < 12; i++) begin
                step(1'b1, nxt, (i % 2) == 0, 1'b0, "toggle", acc);
                if (acc) nxt = nxt + 1;
            end
            for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0, "toggle_drain", acc);
        end

        // Random traffic with occasional flushes.
        for (int i = 0; i < 300; i++) begin
            ordy = ($urandom_range(0, 99) < 60);
            step($urandom_range(0, 1) == 1, $urandom | 32'h8000_0000, ordy,
                 $urandom_range(0, 29) == 0, "random", acc);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0, "final_drain", acc);
        checks++;
        assert (c_CAP >= 1 && model_q.size() == 0 && out_valid === 1'b0) else begin
            errors++; $error("FAIL final_empty out_valid got=%b exp=0", out_valid);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 The block SHALL have the following parameter: PAYLOAD_W, 32, payload bit width; legal range 1..256.
REQ-002 The block SHALL have the following parameter: RESET_PAYLOAD, 0, value loaded into the payload registers on reset.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rstn, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: upstream stage presents a payload.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts the payload this cycle.
REQ-007 The block SHALL have port in_payload, input, PAYLOAD_W bits: upstream payload (e.g. alu result, store data, rd, control bits).
REQ-008 The block SHALL have port flush, input, 1 bit: kill all held entries (branch or trap redirect).
REQ-009 The block SHALL have port out_valid, output, 1 bit: downstream payload is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream consumes the payload this cycle.
REQ-011 The block SHALL have port out_payload, output, PAYLOAD_W bits: payload of the oldest held entry.
REQ-012 The block SHALL have port occupancy, output, 2 bits: number of valid entries held (0..2).

Function
REQ-013 The block SHALL treat a transfer as occurring on a cycle where valid and ready are both 1 at the same port.
REQ-014 The block SHALL present an accepted payload on out_payload with out_valid=1 exactly one cycle after acceptance when it holds no older entry.
REQ-015 The block SHALL deliver entries in acceptance order, with no loss and no duplication.
REQ-016 The block SHALL hold out_payload and out_valid stable while out_valid=1 and out_ready=0.
REQ-017 The block SHALL use, when PIPE_SKID_EN is defined, a 2-entry structure consisting of a main register and a skid register, with states EMPTY (occupancy 0), ONE (occupancy 1) and FULL (occupancy 2).
REQ-018 The block SHALL make the following state transitions:
- EMPTY -> ONE on accept;
- ONE -> EMPTY on output transfer without accept;
- ONE -> ONE on simultaneous accept and output transfer;
- ONE -> FULL on accept without output transfer;
- FULL -> ONE on output transfer, with the skid entry moving to main in the same edge.
REQ-019 The block SHALL drive in_ready from a register that is 1 in states EMPTY and ONE and 0 in state FULL, with no combinational path from out_ready to in_ready.
REQ-020 The block SHALL ignore in_valid while in_ready=0.
REQ-021 The block SHALL make flush=1 force the state to EMPTY at the next edge, with out_valid=0, occupancy=0 and in_ready=1.
REQ-022 The block SHALL give flush priority over a simultaneous accept (payload dropped) and over a simultaneous output transfer (the transfer still counts as consumed downstream).
REQ-023 The block SHALL leave payload registers unchanged on flush; only the valid and state bits clear.
REQ-024 The block SHALL change occupancy only on an accept, an output transfer or a flush.
REQ-025 The block SHALL ignore the payload input when in_valid=0 and ignore out_ready when out_valid=0.

Reset
REQ-026 The block SHALL, while rstn=0, immediately force state EMPTY, out_valid=0, occupancy=0 and out_payload=RESET_PAYLOAD.
REQ-027 The block SHALL force in_ready=1 while rstn=0 when PIPE_SKID_EN is defined.
REQ-028 The block SHALL discard any in-flight entry when reset asserts mid-operation, and SHALL accept the first entry on the first rising edge after rstn deasserts.

Configuration
REQ-029 The block SHALL, when the macro PIPE_SKID_EN is defined, implement the 2-entry skid behaviour of REQ-017 to REQ-019, which gives full throughput with a registered in_ready.
REQ-030 The block SHALL, when PIPE_SKID_EN is not defined, implement a single entry with in_ready = !out_valid || out_ready (combinational) and occupancy limited to 0..1 (bit 1 tied to 0).
REQ-031 The block SHALL keep all other requirements identical with and without PIPE_SKID_EN.

Verification (PAYLOAD_W=32)
REQ-032 The bench SHALL cover streaming: in_valid=1 with payloads 0x1..0x8 on consecutive cycles and out_ready=1 -> out_payload 0x1..0x8 on consecutive cycles, each one cycle after acceptance, and occupancy never above 1.
REQ-033 The bench SHALL cover backpressure (PIPE_SKID_EN defined): out_ready=0 while 0xA, 0xB and 0xC are offered -> 0xA and 0xB accepted, in_ready=0 with occupancy=2, 0xC held upstream; then out_ready=1 -> 0xA, 0xB, 0xC delivered in order.
REQ-034 The bench SHALL cover flush: with occupancy=2, assert flush together with in_valid=1 and payload 0xDEAD -> next cycle out_valid=0, occupancy=0, in_ready=1, and 0xDEAD never appears at the output.
REQ-035 The bench SHALL cover reset mid-operation: drop rstn while holding 0x55 -> out_valid=0 and out_payload=RESET_PAYLOAD immediately; after release, 0x66 appears one cycle after acceptance.
REQ-036 The bench SHALL cover the build without PIPE_SKID_EN: out_ready toggled 1,0,1,0 under continuous input 0x10.. -> in_ready equals !out_valid || out_ready every cycle and no payload is lost.
